life_grid_engine: RTL and testbench
===================================

# life_grid_engine

Parametrised Game-of-Life evolution engine holding the whole cell map in registers and computing one full map row per clock. It generalises the fixed evolve engine with configurable map size, run-time birth/survive rule masks, selectable toroidal or dead-border edges, and LFSR random fill. It reports generation and live-cell counts. It sits between the keyboard command decoder, which issues commands, and the VGA pixel path, which reads cells by coordinate.

## Interface
- MAP_WIDTH, 16, columns; 3..32
- MAP_HEIGHT, 16, rows; ≥3
- X_BITS, 4, column index width; must be ≥ clog2(MAP_WIDTH)
- Y_BITS, 4, row index width; must be ≥ clog2(MAP_HEIGHT)
- GEN_BITS, 16, generation counter width
- POP_BITS, 9, live-count width; must be ≥ clog2(MAP_WIDTH*MAP_HEIGHT+1)
- LFSR_SEED, 32'hACE1_2D5B, reset value of the 32-bit Galois LFSR (taps 32,22,2,1); nonzero

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd  in  3  command code: 0 NOP, 1 STEP, 2 CLEAR, 3 RANDOM, 4 SET_ALIVE, 5 SET_DEAD, 6 TOGGLE, 7 NOP
- cmd_ready  out  1  equals state==IDLE (combinational)
- wr_x / wr_y  in  X_BITS / Y_BITS  target cell for codes 4–6
- rule_birth / rule_survive  in  9 / 9  bit n set = birth / survival with n live neighbours
- wrap  in  1  1 = toroidal edges, 0 = cells outside map are dead
- rd_x / rd_y  in  X_BITS / Y_BITS  read coordinate
- rd_cell  out  1  registered cell value
- busy  out  1  registered; high in STEP, RAND, COMMIT
- done  out  1  one-cycle pulse after COMMIT
- gen_count  out  GEN_BITS  generations since last CLEAR/RANDOM
- pop_count  out  POP_BITS  live cells in current map

## Operation
- Storage: cur[MAP_HEIGHT][MAP_WIDTH] is the displayed map. nxt has the same shape and holds the generation being built.
- States: IDLE, STEP, RAND, COMMIT. A row counter r runs 0..MAP_HEIGHT-1.
- Command acceptance: a command is accepted only when cmd_valid && cmd_ready. Commands presented while busy are dropped, not queued.
- IDLE, STEP accepted:
  - Latch rule_birth, rule_survive and wrap.
  - Set r=0 and go to STEP.
- IDLE, RANDOM accepted: set r=0 and go to RAND.
- IDLE, CLEAR accepted: in the same edge, cur=0, gen_count=0, pop_count=0. Stay in IDLE.
- IDLE, SET_ALIVE / SET_DEAD / TOGGLE accepted:
  - Update cur[wr_y][wr_x] in the same edge.
  - pop_count changes by ±1 only if the cell value actually changes.
  - Out-of-range coordinates are ignored. gen_count is unchanged.
- STEP, each cycle:
  - For every column c of row r, n = count of the 8 neighbours in cur. Neighbours outside the map use the wrapped coordinate if wrap=1, else count as 0.
  - nxt[r][c] = cur[r][c] ? rule_survive[n] : rule_birth[n].
  - Accumulate the row popcount into a running sum.
  - At r=MAP_HEIGHT-1, go to COMMIT; otherwise r++.
- RAND, each cycle:
  - nxt[r] = LFSR[MAP_WIDTH-1:0]; the LFSR advances once; the popcount accumulates.
  - At the last row, go to COMMIT.
- COMMIT:
  - cur=nxt; pop_count=sum.
  - gen_count increments (wrapping 2^GEN_BITS-1→0) if entered from STEP, or is set to 0 if entered from RAND.
  - Go to IDLE.
- cur is not modified during STEP/RAND, so the display shows the old generation until COMMIT.
- Read path: rd_cell <= cur[rd_y][rd_x] every cycle; 0 if the coordinate is out of range.

## Timing
- Reset:
  - State IDLE; cur, nxt, gen_count, pop_count, busy, done and rd_cell all 0; LFSR=LFSR_SEED.
  - A reset mid-STEP/RAND aborts and clears the map; done is not pulsed.
- STEP/RANDOM accepted at edge 0:
  - busy=1 from edge 1 through edge MAP_HEIGHT+1.
  - STEP/RAND occupies cycles 1..MAP_HEIGHT; COMMIT is at edge MAP_HEIGHT+1.
  - At edge MAP_HEIGHT+2: done=1, busy=0, and the new cur, gen_count and pop_count are visible.
  - A new command can be accepted in that cycle (cmd_ready=1).
- Single-cycle commands: visible at edge 1. rd_cell reflects a change one edge after it lands in cur.
- rd_cell latency: 1 clock from rd_x/rd_y.
- Rule and wrap changes during STEP have no effect on that step.

## Test plan
- Reset and idle: assert rst 2 cycles -> full scan of rd_cell gives all 0; pop_count=0, gen_count=0, cmd_ready=1, busy=0.
- Blinker, 16×16, B=9'h008, S=9'h00C, wrap=0:
  - SET_ALIVE (7,6),(7,7),(7,8), then STEP -> done exactly 18 cycles after acceptance; alive cells are (6,7),(7,7),(8,7); pop=3, gen=1.
  - Second STEP -> original cells restored, gen=2.
- Edge wrap, vertical blinker at (15,0),(15,1),(15,2):
  - wrap=1, STEP -> alive (14,1),(15,1),(0,1), pop=3.
  - wrap=0 -> alive (14,1),(15,1), pop=2.
- Busy drop: STEP accepted, SET_ALIVE (0,0) at cycle 3 -> cmd_ready=0 at that cycle; after done, (0,0) is still dead.
- RANDOM then CLEAR:
  - RANDOM -> done at +18, gen=0, and pop_count equals the number of live cells found by a full rd_cell scan.
  - CLEAR -> next cycle pop=0, gen=0, scan all 0.
- Reset mid-step plus generation wrap:
  - rst at cycle 5 of STEP -> next cycle busy=0, map empty, no done pulse.
  - With GEN_BITS=2, 4 STEPs -> gen_count 1,2,3,0.

Source files
------------

// File: rtl/life_grid_engine.sv
// Game-of-Life engine: the whole map lives in flops and one row is evolved per clock.
// life_cell evaluates the next state of one column of the active row.

module life_cell (
  input  logic [7:0] nbr,
  input  logic       self_q,
  input  logic [8:0] birth,
  input  logic [8:0] survive,
  output logic       cell_nxt
);
  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(nbr[i]);
  end

  assign cell_nxt = self_q ? survive[n] : birth[n];
endmodule

module life_grid_engine #(
  parameter int          MAP_WIDTH  = 16,
  parameter int          MAP_HEIGHT = 16,
  parameter int          X_BITS     = 4,
  parameter int          Y_BITS     = 4,
  parameter int          GEN_BITS   = 16,
  parameter int          POP_BITS   = 9,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2D5B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd,
  output logic                cmd_ready,
  input  logic [X_BITS-1:0]   wr_x,
  input  logic [Y_BITS-1:0]   wr_y,
  input  logic [8:0]          rule_birth,
  input  logic [8:0]          rule_survive,
  input  logic                wrap,
  input  logic [X_BITS-1:0]   rd_x,
  input  logic [Y_BITS-1:0]   rd_y,
  output logic                rd_cell,
  output logic                busy,
  output logic                done,
  output logic [GEN_BITS-1:0] gen_count,
  output logic [POP_BITS-1:0] pop_count
);
  localparam logic [2:0] CMD_STEP      = 3'd1;
  localparam logic [2:0] CMD_CLEAR     = 3'd2;
  localparam logic [2:0] CMD_RANDOM    = 3'd3;
  localparam logic [2:0] CMD_SET_ALIVE = 3'd4;
  localparam logic [2:0] CMD_SET_DEAD  = 3'd5;
  localparam logic [2:0] CMD_TOGGLE    = 3'd6;

  typedef enum logic [1:0] {IDLE, STEP, RAND, COMMIT} state_t;

  state_t                               state;
  logic [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] cur, nxt, wr_mask;
  logic [Y_BITS-1:0]                    r;
  logic [POP_BITS-1:0]                  sum, row_pop;
  logic [8:0]                           birth_q, survive_q;
  logic                                 wrap_q, from_rand;
  logic [31:0]                          lfsr, lfsr_nxt;
  logic [MAP_WIDTH-1:0]                 row_up, row_mid, row_dn, row_new, row_val;
  logic                                 cmd_fire, last_row;
  logic                                 cell_q, cell_new, cell_hit, rd_bit;

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign last_row  = (r == Y_BITS'(MAP_HEIGHT - 1));
  // Galois form, taps 32,22,2,1
  assign lfsr_nxt  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

  // Rows above and below r; off-map rows read as dead unless wrapping
  always_comb begin
    row_up  = '0;
    row_mid = '0;
    row_dn  = '0;
    for (int i = 0; i < MAP_HEIGHT; i++) begin
      if (r == Y_BITS'(i)) begin
        row_mid = cur[i];
        if (i != 0 || wrap_q) row_up = cur[(i + MAP_HEIGHT - 1) % MAP_HEIGHT];
        if (i != MAP_HEIGHT - 1 || wrap_q) row_dn = cur[(i + 1) % MAP_HEIGHT];
      end
    end
  end

  for (genvar c = 0; c < MAP_WIDTH; c++) begin : g_col
    localparam int CL = (c + MAP_WIDTH - 1) % MAP_WIDTH;
    localparam int CR = (c + 1) % MAP_WIDTH;
    logic lv, rv;
    assign lv = (c != 0) || wrap_q;
    assign rv = (c != MAP_WIDTH - 1) || wrap_q;
    life_cell u_cell (
      .nbr      ({row_up[CL] & lv,  row_up[c],  row_up[CR] & rv,
                  row_mid[CL] & lv,             row_mid[CR] & rv,
                  row_dn[CL] & lv,  row_dn[c],  row_dn[CR] & rv}),
      .self_q   (row_mid[c]),
      .birth    (birth_q),
      .survive  (survive_q),
      .cell_nxt (row_new[c])
    );
  end

  always_comb begin
    row_val = (state == RAND) ? lfsr[MAP_WIDTH-1:0] : row_new;
    row_pop = '0;
    for (int c = 0; c < MAP_WIDTH; c++) row_pop = row_pop + POP_BITS'(row_val[c]);
  end

  // Coordinate decode; out-of-range coordinates match no cell
  always_comb begin
    wr_mask = '0;
    cell_q  = 1'b0;
    rd_bit  = 1'b0;
    for (int i = 0; i < MAP_HEIGHT; i++) begin
      for (int j = 0; j < MAP_WIDTH; j++) begin
        if (wr_y == Y_BITS'(i) && wr_x == X_BITS'(j)) begin
          wr_mask[i][j] = 1'b1;
          cell_q        = cur[i][j];
        end
        if (rd_y == Y_BITS'(i) && rd_x == X_BITS'(j)) rd_bit = cur[i][j];
      end
    end
    cell_hit = |wr_mask;
    cell_new = 1'b0;
    case (cmd)
      CMD_SET_ALIVE: cell_new = 1'b1;
      CMD_SET_DEAD:  cell_new = 1'b0;
      default:       cell_new = ~cell_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      nxt       <= '0;
      r         <= '0;
      sum       <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      wrap_q    <= 1'b0;
      from_rand <= 1'b0;
      lfsr      <= LFSR_SEED;
      gen_count <= '0;
      pop_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_cell   <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_cell <= rd_bit;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd)
              CMD_STEP: begin
                birth_q   <= rule_birth;
                survive_q <= rule_survive;
                wrap_q    <= wrap;
                from_rand <= 1'b0;
                r         <= '0;
                sum       <= '0;
                busy      <= 1'b1;
                state     <= STEP;
              end
              CMD_RANDOM: begin
                from_rand <= 1'b1;
                r         <= '0;
                sum       <= '0;
                busy      <= 1'b1;
                state     <= RAND;
              end
              CMD_CLEAR: begin
                cur       <= '0;
                gen_count <= '0;
                pop_count <= '0;
              end
              CMD_SET_ALIVE, CMD_SET_DEAD, CMD_TOGGLE: begin
                if (cell_hit && (cell_new != cell_q)) begin
                  for (int i = 0; i < MAP_HEIGHT; i++)
                    for (int j = 0; j < MAP_WIDTH; j++)
                      if (wr_mask[i][j]) cur[i][j] <= cell_new;
                  pop_count <= cell_new ? pop_count + POP_BITS'(1) : pop_count - POP_BITS'(1);
                end
              end
              default: ;
            endcase
          end
        end
        STEP, RAND: begin
          for (int i = 0; i < MAP_HEIGHT; i++)
            if (r == Y_BITS'(i)) nxt[i] <= row_val;
          sum <= sum + row_pop;
          if (state == RAND) lfsr <= lfsr_nxt;
          if (last_row) state <= COMMIT;
          else          r     <= r + Y_BITS'(1);
        end
        COMMIT: begin
          cur       <= nxt;
          pop_count <= sum;
          gen_count <= from_rand ? '0 : gen_count + GEN_BITS'(1);
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: directed 16x16 scenarios plus a randomized 5x4 run
// against an arithmetic Life model.

module tb_life_grid_engine;
  localparam logic [2:0] C_NOP = 3'd0, C_STEP = 3'd1, C_CLEAR = 3'd2, C_RANDOM = 3'd3;
  localparam logic [2:0] C_SET = 3'd4, C_DEAD = 3'd5, C_TOG = 3'd6, C_NOP7 = 3'd7;
  localparam logic [31:0] SEED = 32'hACE1_2D5B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16x16 instance
  logic        rst, cmd_valid, wrap, cmd_ready, rd_cell, busy, done;
  logic [2:0]  cmd;
  logic [3:0]  wr_x, wr_y, rd_x, rd_y;
  logic [8:0]  rule_birth, rule_survive, pop_count;
  logic [15:0] gen_count;

  // 5x4 instance with a 2-bit generation counter
  logic        b_rst, b_cmd_valid, b_wrap, b_cmd_ready, b_rd_cell, b_busy, b_done;
  logic [2:0]  b_cmd, b_wr_x, b_rd_x;
  logic [1:0]  b_wr_y, b_rd_y, b_gen;
  logic [8:0]  b_rule_birth, b_rule_survive;
  logic [4:0]  b_pop;

  life_grid_engine u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .wr_x(wr_x), .wr_y(wr_y), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .wrap(wrap), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .busy(busy), .done(done),
    .gen_count(gen_count), .pop_count(pop_count)
  );

  life_grid_engine #(
    .MAP_WIDTH(5), .MAP_HEIGHT(4), .X_BITS(3), .Y_BITS(2), .GEN_BITS(2), .POP_BITS(5)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd(b_cmd), .cmd_ready(b_cmd_ready),
    .wr_x(b_wr_x), .wr_y(b_wr_y), .rule_birth(b_rule_birth), .rule_survive(b_rule_survive),
    .wrap(b_wrap), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_cell(b_rd_cell), .busy(b_busy),
    .done(b_done), .gen_count(b_gen), .pop_count(b_pop)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] cmd;
    logic [3:0] x;
    logic [3:0] y;
    int         exp_pop;
    logic       exp_cell;
  } vec_t;
  vec_t vecs [12];

  bit scan_map [16][16];
  bit exp_map  [16][16];
  int scan_cnt;
  logic [31:0] lfsr_a, lfsr_b;
  bit mb [4][5];
  int gen_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // ---------------- 16x16 helpers ----------------
  task automatic issue(input logic [2:0] c, input int x, input int y);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wr_x = 4'(x); wr_y = 4'(y);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic scan();
    scan_cnt = 0;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) begin
        scan_map[(i-1)/16][(i-1)%16] = rd_cell;
        scan_cnt += int'(rd_cell);
      end
      if (i < 256) begin rd_x = 4'(i % 16); rd_y = 4'(i / 16); end
    end
  endtask

  task automatic clear_exp();
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) exp_map[y][x] = 1'b0;
  endtask

  function automatic int diff_map();
    int d = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) if (scan_map[y][x] != exp_map[y][x]) d++;
    return d;
  endfunction

  // mode 1: scramble rules/wrap mid-run; mode 2: present SET_ALIVE(0,0) while busy
  task automatic run_long(input logic [2:0] c, input int mode, output int done_cyc);
    done_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin cmd_valid = 1'b0; chk("busy_rise", int'(busy), 1); end
      if (cyc == 2 && mode == 1) begin rule_birth = '0; rule_survive = '1; wrap = ~wrap; end
      if (cyc == 3 && mode == 2) begin
        chk("busy_ready_low", int'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd = C_SET; wr_x = 4'd0; wr_y = 4'd0;
      end
      if (cyc == 4 && mode == 2) cmd_valid = 1'b0;
      if (cyc == 17) chk("busy_before_commit", int'(busy), 1);
      if (done) done_cyc = cyc;
    end
    chk("busy_after_done", int'(busy), 0);
  endtask

  // ---------------- 5x4 helpers ----------------
  task automatic b_issue(input logic [2:0] c, input logic [2:0] x, input logic [1:0] y);
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd = c; b_wr_x = x; b_wr_y = y;
    @(negedge clk);
    b_cmd_valid = 1'b0;
  endtask

  task automatic b_long(input logic [2:0] c);
    int dc;
    dc = 0;
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd = c;
    for (int cyc = 1; cyc <= 20 && dc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) b_cmd_valid = 1'b0;
      if (b_done) dc = cyc;
    end
    chk("b_done_cycle", dc, 6);
  endtask

  task automatic model_step_b(input logic [8:0] bb, input logic [8:0] ss, input bit w);
    bit nm [4][5];
    int n, yy, xx;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 5; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            yy = y + dy; xx = x + dx;
            if (w) n += int'(mb[(yy + 4) % 4][(xx + 5) % 5]);
            else if (yy >= 0 && yy < 4 && xx >= 0 && xx < 5) n += int'(mb[yy][xx]);
          end
        nm[y][x] = mb[y][x] ? ss[n] : bb[n];
      end
    mb = nm;
  endtask

  function automatic int mb_count();
    int n = 0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 5; x++) n += int'(mb[y][x]);
    return n;
  endfunction

  task automatic b_scan_diff(output int d);
    d = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0 && b_rd_cell != mb[(i-1)/5][(i-1)%5]) d++;
      if (i < 20) begin b_rd_x = 3'(i % 5); b_rd_y = 2'(i / 5); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc, d, op, seen;
    logic [2:0] c, x;
    logic [1:0] y;
    logic [8:0] bb, ss;
    logic w;
    logic [31:0] s;

    vecs[0]  = '{C_SET,  4'd3,  4'd4,  1, 1'b1};
    vecs[1]  = '{C_SET,  4'd3,  4'd4,  1, 1'b1};
    vecs[2]  = '{C_TOG,  4'd3,  4'd4,  0, 1'b0};
    vecs[3]  = '{C_TOG,  4'd3,  4'd4,  1, 1'b1};
    vecs[4]  = '{C_DEAD, 4'd3,  4'd4,  0, 1'b0};
    vecs[5]  = '{C_DEAD, 4'd3,  4'd4,  0, 1'b0};
    vecs[6]  = '{C_SET,  4'd15, 4'd15, 1, 1'b1};
    vecs[7]  = '{C_SET,  4'd0,  4'd0,  2, 1'b1};
    vecs[8]  = '{C_NOP,  4'd0,  4'd0,  2, 1'b1};
    vecs[9]  = '{C_NOP7, 4'd15, 4'd15, 2, 1'b1};
    vecs[10] = '{C_TOG,  4'd0,  4'd15, 3, 1'b1};
    vecs[11] = '{C_CLEAR,4'd15, 4'd15, 0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
    rule_birth = 9'h008; rule_survive = 9'h00C; wrap = 1'b0;
    b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd = C_NOP; b_wr_x = '0; b_wr_y = '0;
    b_rd_x = '0; b_rd_y = '0; b_rule_birth = '0; b_rule_survive = '0; b_wrap = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lfsr_a = SEED;
    @(negedge clk);
    chk("reset_pop", int'(pop_count), 0);
    chk("reset_gen", int'(gen_count), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    scan();
    chk("reset_scan", scan_cnt, 0);

    // Single-cycle command table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd = vecs[i].cmd; wr_x = vecs[i].x; wr_y = vecs[i].y;
      rd_x = vecs[i].x; rd_y = vecs[i].y;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("vec%0d_pop", i), int'(pop_count), vecs[i].exp_pop);
      chk($sformatf("vec%0d_gen", i), int'(gen_count), 0);
      @(negedge clk);
      chk($sformatf("vec%0d_cell", i), int'(rd_cell), int'(vecs[i].exp_cell));
    end

    // Blinker, dead border
    rule_birth = 9'h008; rule_survive = 9'h00C; wrap = 1'b0;
    issue(C_SET, 7, 6); issue(C_SET, 7, 7); issue(C_SET, 7, 8);
    run_long(C_STEP, 0, dc);
    chk("blinker_done_cycle", dc, 18);
    chk("blinker_pop1", int'(pop_count), 3);
    chk("blinker_gen1", int'(gen_count), 1);
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
    clear_exp(); exp_map[7][6] = 1; exp_map[7][7] = 1; exp_map[7][8] = 1;
    scan();
    chk("blinker_map1", diff_map(), 0);
    run_long(C_STEP, 0, dc);
    chk("blinker_done_cycle2", dc, 18);
    chk("blinker_gen2", int'(gen_count), 2);
    chk("blinker_pop2", int'(pop_count), 3);
    clear_exp(); exp_map[6][7] = 1; exp_map[7][7] = 1; exp_map[8][7] = 1;
    scan();
    chk("blinker_map2", diff_map(), 0);

    // Edge blinker with wrap; rules scrambled mid-step must not matter
    issue(C_CLEAR, 0, 0);
    issue(C_SET, 15, 0); issue(C_SET, 15, 1); issue(C_SET, 15, 2);
    wrap = 1'b1;
    run_long(C_STEP, 1, dc);
    chk("wrap_pop", int'(pop_count), 3);
    chk("wrap_gen", int'(gen_count), 1);
    clear_exp(); exp_map[1][14] = 1; exp_map[1][15] = 1; exp_map[1][0] = 1;
    scan();
    chk("wrap_map", diff_map(), 0);
    rule_birth = 9'h008; rule_survive = 9'h00C; wrap = 1'b0;
    issue(C_CLEAR, 0, 0);
    issue(C_SET, 15, 0); issue(C_SET, 15, 1); issue(C_SET, 15, 2);
    run_long(C_STEP, 0, dc);
    chk("nowrap_pop", int'(pop_count), 2);
    clear_exp(); exp_map[1][14] = 1; exp_map[1][15] = 1;
    scan();
    chk("nowrap_map", diff_map(), 0);

    // Command while busy is dropped
    issue(C_CLEAR, 0, 0);
    run_long(C_STEP, 2, dc);
    chk("drop_done_cycle", dc, 18);
    rd_x = 4'd0; rd_y = 4'd0;
    @(negedge clk); @(negedge clk);
    chk("drop_cell", int'(rd_cell), 0);
    chk("drop_pop", int'(pop_count), 0);

    // RANDOM fill from the LFSR, then CLEAR
    s = lfsr_a;
    for (int r = 0; r < 16; r++) begin
      for (int cc = 0; cc < 16; cc++) exp_map[r][cc] = s[cc];
      s = lfsr_adv(s);
    end
    lfsr_a = s;
    run_long(C_RANDOM, 0, dc);
    chk("rand_done_cycle", dc, 18);
    chk("rand_gen", int'(gen_count), 0);
    scan();
    chk("rand_pop_vs_scan", int'(pop_count), scan_cnt);
    chk("rand_map", diff_map(), 0);
    run_long(C_STEP, 0, dc);
    chk("rand_step_gen", int'(gen_count), 1);
    issue(C_CLEAR, 0, 0);
    chk("clear_pop", int'(pop_count), 0);
    chk("clear_gen", int'(gen_count), 0);
    scan();
    chk("clear_scan", scan_cnt, 0);

    // Reset in the middle of a STEP
    issue(C_SET, 1, 1); issue(C_SET, 2, 1); issue(C_SET, 3, 1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_STEP;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cmd_valid = 1'b0;
      if (cyc == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    lfsr_a = SEED;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pop", int'(pop_count), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("midrst_no_done", seen, 0);
    scan();
    chk("midrst_scan", scan_cnt, 0);

    // 5x4 instance: generation wrap, then randomized model comparison
    @(negedge clk);
    b_rst = 1'b0;
    lfsr_b = SEED;
    gen_b = 0;
    for (int yy = 0; yy < 4; yy++) for (int xx = 0; xx < 5; xx++) mb[yy][xx] = 1'b0;
    @(negedge clk);
    chk("b_reset_pop", int'(b_pop), 0);
    for (int k = 1; k <= 4; k++) begin
      b_long(C_STEP);
      chk($sformatf("b_gen_wrap%0d", k), int'(b_gen), k % 4);
    end
    gen_b = 0;

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 11);
      if (op <= 5) begin
        c = 3'(4 + $urandom_range(0, 2));
        x = 3'($urandom_range(0, 7));
        y = 2'($urandom_range(0, 3));
        if (x < 3'd5) begin
          if (c == C_SET)       mb[y][x] = 1'b1;
          else if (c == C_DEAD) mb[y][x] = 1'b0;
          else                  mb[y][x] = ~mb[y][x];
        end
        b_issue(c, x, y);
      end else if (op <= 8) begin
        bb = 9'($urandom); ss = 9'($urandom); w = 1'($urandom);
        b_rule_birth = bb; b_rule_survive = ss; b_wrap = w;
        model_step_b(bb, ss, w);
        gen_b = (gen_b + 1) % 4;
        b_long(C_STEP);
      end else if (op == 9) begin
        for (int r = 0; r < 4; r++) begin
          for (int cc = 0; cc < 5; cc++) mb[r][cc] = lfsr_b[cc];
          lfsr_b = lfsr_adv(lfsr_b);
        end
        gen_b = 0;
        b_long(C_RANDOM);
      end else if (op == 10) begin
        for (int yy = 0; yy < 4; yy++) for (int xx = 0; xx < 5; xx++) mb[yy][xx] = 1'b0;
        gen_b = 0;
        b_issue(C_CLEAR, 3'd0, 2'd0);
      end else begin
        b_issue(($urandom_range(0, 1) != 0) ? C_NOP7 : C_NOP, 3'd1, 2'd1);
      end
      chk($sformatf("b_it%0d_pop", it), int'(b_pop), mb_count());
      chk($sformatf("b_it%0d_gen", it), int'(b_gen), gen_b);
      b_scan_diff(d);
      chk($sformatf("b_it%0d_map", it), d, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
